window_scan_ctrl: RTL

Sequencer for the 3x3 window buffer in the Sobel edge detection pipeline. On `start`, it fetches pixels from the frame memory and issues `start_read`/`start_shift` commands to the window buffer, walking the window over the whole image in serpentine order. At each position it hands the full window to the Sobel compute stage through a valid/ack handshake. When the last position is acknowledged, it pulses `frame_done`.

---
 rtl/window_scan_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/window_scan_ctrl.sv
// rtl/window_scan_ctrl.sv - serpentine 3x3 window scan sequencer for the Sobel window buffer
// Optional stall counter output stall_cycles enabled by defining WINDOW_SCAN_PERF_EN.
module window_scan_ctrl #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       start,
    output logic                       mem_ren,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_rvalid,
    input  logic [7:0]                 mem_rdata,
    output logic                       start_read,
    output logic [7:0]                 data_r,
    input  logic                       read_done,
    output logic                       start_shift,
    output logic [1:0]                 shift_direc,
    input  logic                       shift_done,
    output logic                       win_valid,
    input  logic                       win_ack,
    output logic [$clog2(IMG_W)-1:0]   win_x,
    output logic [$clog2(IMG_H)-1:0]   win_y,
    output logic                       busy,
    output logic                       frame_done
`ifdef WINDOW_SCAN_PERF_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    // Move codes double as the pixel-list selector; 00 is the full fill list.
    localparam logic [1:0] L_FILL  = 2'b00;
    localparam logic [1:0] M_RIGHT = 2'b01;
    localparam logic [1:0] M_DOWN  = 2'b10;
    localparam logic [1:0] M_LEFT  = 2'b11;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, PRESENT, DONE} state_t;

    state_t      state, next_state;
    logic [3:0]  pix_cnt;
    logic        dir_right;
    logic [1:0]  list_sel;
    logic [1:0]  move_dir;
    logic [1:0]  next_move;
    logic        issued;
    logic        last_pix;
    logic [1:0]  frow, fcol;
    logic [ADDR_W-1:0] row, col;

    assign last_pix = (pix_cnt == ((list_sel == L_FILL) ? 4'd8 : 4'd2));

    always_comb begin
        next_move = 2'b00;
        if (dir_right && (win_x < XW'(IMG_W - 3)))
            next_move = M_RIGHT;
        else if (!dir_right && (win_x != '0))
            next_move = M_LEFT;
        else if (win_y < YW'(IMG_H - 3))
            next_move = M_DOWN;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   if (mem_rvalid) next_state = LOAD;
            LOAD:    if (read_done) next_state = last_pix ? PRESENT : FETCH;
            PRESENT: if (win_ack) next_state = (next_move == 2'b00) ? DONE : SHIFT;
            SHIFT:   if (shift_done) next_state = FETCH;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win_x     <= '0;
            win_y     <= '0;
            pix_cnt   <= '0;
            dir_right <= 1'b0;
            list_sel  <= L_FILL;
            move_dir  <= 2'b00;
            issued    <= 1'b0;
            data_r    <= '0;
        end else begin
            // Marks that the one-cycle command pulse of LOAD/SHIFT has gone out.
            issued <= (next_state == state) && ((state == LOAD) || (state == SHIFT));
            case (state)
                IDLE: if (start) begin
                    win_x     <= '0;
                    win_y     <= '0;
                    pix_cnt   <= '0;
                    dir_right <= 1'b1;
                    list_sel  <= L_FILL;
                end
                FETCH: if (mem_rvalid) data_r <= mem_rdata;
                LOAD:  if (read_done) pix_cnt <= pix_cnt + 4'd1;
                PRESENT: if (win_ack) begin
                    move_dir <= next_move;
                    if (next_move == M_DOWN) dir_right <= ~dir_right;
                end
                SHIFT: if (shift_done) begin
                    case (move_dir)
                        M_RIGHT: win_x <= win_x + XW'(1);
                        M_LEFT:  win_x <= win_x - XW'(1);
                        M_DOWN:  win_y <= win_y + YW'(1);
                        default: ;
                    endcase
                    pix_cnt  <= '0;
                    list_sel <= move_dir;
                end
                default: ;
            endcase
        end
    end

    // Fill list walks bottom row first, left to right.
    always_comb begin
        if (pix_cnt < 4'd3) begin
            frow = 2'd2;
            fcol = pix_cnt[1:0];
        end else if (pix_cnt < 4'd6) begin
            frow = 2'd1;
            fcol = 2'(pix_cnt - 4'd3);
        end else begin
            frow = 2'd0;
            fcol = 2'(pix_cnt - 4'd6);
        end
    end

    always_comb begin
        row = ADDR_W'(win_y);
        col = ADDR_W'(win_x);
        case (list_sel)
            L_FILL: begin
                row = row + ADDR_W'(frow);
                col = col + ADDR_W'(fcol);
            end
            M_RIGHT: begin
                row = row + ADDR_W'(pix_cnt);
                col = col + ADDR_W'(2);
            end
            M_LEFT:  row = row + ADDR_W'(pix_cnt);
            default: begin
                row = row + ADDR_W'(2);
                col = col + ADDR_W'(pix_cnt);
            end
        endcase
    end

    always_comb begin
        mem_ren     = (state == FETCH);
        mem_addr    = '0;
        if (state == FETCH) mem_addr = row * ADDR_W'(IMG_W) + col;
        start_read  = (state == LOAD) && !issued;
        start_shift = (state == SHIFT) && !issued;
        shift_direc = (state == SHIFT) ? move_dir : 2'b00;
        win_valid   = (state == PRESENT);
        busy        = (state != IDLE) && (state != DONE);
        frame_done  = (state == DONE);
    end

`ifdef WINDOW_SCAN_PERF_EN
    logic waiting;
    assign waiting = ((state == FETCH) && !mem_rvalid) ||
                     ((state == LOAD)  && !read_done)  ||
                     ((state == SHIFT) && !shift_done);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            stall_cycles <= '0;
        else if ((state == IDLE) && start)
            stall_cycles <= '0;
        else if (waiting && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
